// File: rtl/tetris_pkg.sv
// Shared constants, state encodings and colour helpers for the
// Tetris board renderer and its cell RAM.
package tetris_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int CELLS   = BOARD_W * BOARD_H;
    localparam int COLOR_W = 3;
    localparam int ADDR_W  = 8;

    localparam logic [11:0] RGB_BLACK  = 12'h000;
    localparam logic [11:0] RGB_BORDER = 12'h888;
    localparam logic [11:0] RGB_BG     = 12'h112;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } clr_state_t;

    typedef enum logic [1:0] {
        PX_BG,
        PX_BORDER,
        PX_PLAY
    } px_class_t;

    function automatic logic [11:0] palette(
        input logic [COLOR_W-1:0] idx
    );
        logic [11:0] rgb;
        case (idx)
            3'd0:    rgb = 12'h000;
            3'd1:    rgb = 12'h0FF;
            3'd2:    rgb = 12'hFF0;
            3'd3:    rgb = 12'hF0F;
            3'd4:    rgb = 12'h0F0;
            3'd5:    rgb = 12'hF00;
            3'd6:    rgb = 12'h00F;
            default: rgb = 12'hF80;
        endcase
        return rgb;
    endfunction

    // row*10 + col without a multiplier; only called with in-range cells
    function automatic logic [ADDR_W-1:0] cell_addr(
        input logic [4:0] row,
        input logic [3:0] col
    );
        logic [ADDR_W-1:0] r8;
        r8 = {3'b000, row};
        return (r8 << 3) + (r8 << 1) + {4'b0000, col};
    endfunction

endpackage

// File: rtl/tetris_board_ram.sv
// 200x3 simple dual-port cell RAM: one write port, one
// registered read port gated by the pixel strobe.
module tetris_board_ram
    import tetris_pkg::*;
(
    input  logic               i_clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [COLOR_W-1:0] wdata,
    input  logic               re,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [COLOR_W-1:0] rdata
);

    logic [COLOR_W-1:0] mem [CELLS];

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/tetris_board_renderer.sv
// Pixel-colour stage behind the 640x400 VGA timing generator:
// holds the 10x20 board and renders playfield, frame and background.
module tetris_board_renderer
    import tetris_pkg::*;
#(
    parameter int   BOARD_X   = 240,
    parameter int   BOARD_Y   = 40,
    parameter int   CELL_PX   = 16,
    parameter int   BORDER_PX = 4,
    parameter logic VS_ACTIVE = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pix_stb,
    input  logic [9:0] i_x,
    input  logic [8:0] i_y,
    input  logic       i_active,
    input  logic       i_blanking,
    input  logic       i_hs,
    input  logic       i_vs,
    input  logic       i_wr_req,
    input  logic [3:0] i_wr_col,
    input  logic [4:0] i_wr_row,
    input  logic [2:0] i_wr_color,
    output logic       o_wr_ack,
    output logic       o_ready,
    output logic [3:0] o_r,
    output logic [3:0] o_g,
    output logic [3:0] o_b,
    output logic       o_hs,
    output logic       o_vs
);

    localparam int SH = $clog2(CELL_PX);

    localparam logic [9:0] PX_X0 = 10'(BOARD_X);
    localparam logic [9:0] PX_X1 = 10'(BOARD_X + BOARD_W * CELL_PX);
    localparam logic [8:0] PX_Y0 = 9'(BOARD_Y);
    localparam logic [8:0] PX_Y1 = 9'(BOARD_Y + BOARD_H * CELL_PX);
    localparam logic [9:0] BD_X0 = 10'(BOARD_X - BORDER_PX);
    localparam logic [9:0] BD_X1 = 10'(BOARD_X + BOARD_W * CELL_PX + BORDER_PX);
    localparam logic [8:0] BD_Y0 = 9'(BOARD_Y - BORDER_PX);
    localparam logic [8:0] BD_Y1 = 9'(BOARD_Y + BOARD_H * CELL_PX + BORDER_PX);
    localparam logic [9:0] X_MASK = 10'(CELL_PX - 1);
    localparam logic [8:0] Y_MASK = 9'(CELL_PX - 1);

    clr_state_t         state;
    clr_state_t         state_nxt;
    logic [ADDR_W-1:0]  clr_addr;
    logic [ADDR_W-1:0]  clr_addr_nxt;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_waddr;
    logic [COLOR_W-1:0] ram_wdata;
    logic [COLOR_W-1:0] ram_rdata;
    logic               wr_in_range;

    assign wr_in_range = (i_wr_col < 4'(BOARD_W)) && (i_wr_row < 5'(BOARD_H));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        ram_we       = 1'b0;
        ram_waddr    = clr_addr;
        ram_wdata    = '0;
        o_wr_ack     = 1'b0;
        unique case (state)
            ST_CLEAR: begin
                // clr_addr == CELLS means the last cell was written last clk
                if (clr_addr == 8'(CELLS)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    ram_we       = 1'b1;
                    clr_addr_nxt = clr_addr + 8'd1;
                end
            end
            ST_IDLE: begin
                if (i_wr_req && i_blanking && !i_rst) begin
                    o_wr_ack  = 1'b1;
                    ram_we    = wr_in_range;
                    ram_waddr = cell_addr(i_wr_row, i_wr_col);
                    ram_wdata = i_wr_color;
                end
            end
        endcase
    end

    assign o_ready = (state == ST_IDLE);

    logic [9:0]        dx;
    logic [8:0]        dy;
    logic              in_play;
    logic              in_frame;
    logic              on_grid;
    logic [ADDR_W-1:0] rd_addr;
    px_class_t         px_class;

    assign dx = i_x - PX_X0;
    assign dy = i_y - PX_Y0;

    assign in_play = (i_x >= PX_X0) && (i_x < PX_X1) &&
                     (i_y >= PX_Y0) && (i_y < PX_Y1);
    assign in_frame = (i_x >= BD_X0) && (i_x < BD_X1) &&
                      (i_y >= BD_Y0) && (i_y < BD_Y1);
    assign on_grid = ((dx & X_MASK) == '0) || ((dy & Y_MASK) == '0);

    assign rd_addr = in_play ? cell_addr(5'(dy >> SH), 4'(dx >> SH)) : '0;

    always_comb begin
        px_class = PX_BG;
        if (in_play) begin
            px_class = PX_PLAY;
        end else if (in_frame) begin
            px_class = PX_BORDER;
        end
    end

    tetris_board_ram u_ram (
        .i_clk (i_clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (i_pix_stb),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    px_class_t s1_class;
    logic      s1_active;
    logic      s1_grid;
    logic      s1_ready;
    logic      s1_hs;
    logic      s1_vs;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_class  <= PX_BG;
            s1_active <= 1'b0;
            s1_grid   <= 1'b0;
            s1_ready  <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= ~VS_ACTIVE;
        end else if (i_pix_stb) begin
            s1_class  <= px_class;
            s1_active <= i_active;
            s1_grid   <= on_grid;
            s1_ready  <= o_ready;
            s1_hs     <= i_hs;
            s1_vs     <= i_vs;
        end
    end

    logic [11:0] rgb;
    logic [11:0] rgb_nxt;

    // grid pixels of an empty cell are black via palette(0) anyway
    always_comb begin
        rgb_nxt = RGB_BG;
        unique case (1'b1)
            !s1_active:
                rgb_nxt = RGB_BLACK;
            s1_active && (s1_class == PX_PLAY):
                rgb_nxt = (s1_ready && !s1_grid) ? palette(ram_rdata) : RGB_BLACK;
            s1_active && (s1_class == PX_BORDER):
                rgb_nxt = RGB_BORDER;
            default:
                rgb_nxt = RGB_BG;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rgb  <= '0;
            o_hs <= 1'b1;
            o_vs <= ~VS_ACTIVE;
        end else if (i_pix_stb) begin
            rgb  <= rgb_nxt;
            o_hs <= s1_hs;
            o_vs <= s1_vs;
        end
    end

    assign o_r = rgb[11:8];
    assign o_g = rgb[7:4];
    assign o_b = rgb[3:0];

endmodule
